// File: rtl/bpw_pkg.sv
// Shared types and helpers for the bad-point list writer.
package bpw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WAIT_WIN,
        COMMIT,
        PUBLISH
    } bpw_state_e;

    localparam int BAD_POINT_BIT_DEF = 7;
    localparam int CAP               = (1 << BAD_POINT_BIT_DEF) - 1;

    // LUT word layout consumed by the manual bad-pixel checker: {Y, X}.
    function automatic logic [31:0] pack_coord(input logic [15:0] y, input logic [15:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/bpw_stage_ram.sv
// Staging store for one frame's detections: simple dual-port, registered read.
module bpw_stage_ram #(
    parameter int DEPTH = 127,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bad_point_list_writer.sv
// Collects per-frame bad-pixel detections, then copies them into the coordinate LUT
// during the update window and publishes the count. Optional: BPW_ROW_MERGE_EN.
module bad_point_list_writer
    import bpw_pkg::*;
#(
    parameter int WIDTH_BITS    = 10,
    parameter int HEIGHT_BITS   = 10,
    parameter int BAD_POINT_BIT = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     frame_end,
    input  logic                     det_valid,
    input  logic [WIDTH_BITS-1:0]    det_x,
    input  logic [HEIGHT_BITS-1:0]   det_y,
    input  logic                     update_allow,
    output logic                     wen_lut,
    output logic [BAD_POINT_BIT-1:0] waddr_lut,
    output logic [31:0]              wdata_lut,
    output logic [BAD_POINT_BIT-1:0] bad_point_num,
    output logic                     commit_done,
    output logic                     overflow,
    output logic                     busy
);

    localparam int                     CAP_N = (1 << BAD_POINT_BIT) - 1;
    localparam logic [BAD_POINT_BIT-1:0] CAP_V = BAD_POINT_BIT'(CAP_N);
    localparam logic [BAD_POINT_BIT-1:0] ONE   = BAD_POINT_BIT'(1);

    bpw_state_e state_q, state_d;

    logic                     fs_q;
    logic [BAD_POINT_BIT-1:0] count_q;
    logic                     overflow_q;
    logic [BAD_POINT_BIT-1:0] rd_ptr_q, rd_addr_q;
    logic                     rd_vld_q;
    logic                     wen_q;
    logic [BAD_POINT_BIT-1:0] waddr_q;
    logic [31:0]              wdata_q;
    logic [BAD_POINT_BIT-1:0] bpn_q;
    logic                     done_q;
    logic [31:0]              ram_rdata;

    logic fs_rise, merge_hit, start_coll, accept, drop_ovf, rd_en, last_wr;

    assign fs_rise = frame_start & ~fs_q;
    assign rd_en   = (state_q == COMMIT) && (rd_ptr_q < count_q);
    assign last_wr = wen_q && (waddr_q == count_q - ONE);

`ifdef BPW_ROW_MERGE_EN
    logic                   last_vld_q;
    logic [WIDTH_BITS-1:0]  last_x_q;
    logic [HEIGHT_BITS-1:0] last_y_q;

    // Neighbours within the consumer's 5x5 window on the same row add nothing.
    assign merge_hit = last_vld_q && (det_y == last_y_q) &&
                       ({1'b0, det_x} <= {1'b0, last_x_q} + (WIDTH_BITS + 1)'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld_q <= 1'b0;
            last_x_q   <= '0;
            last_y_q   <= '0;
        end else if (start_coll) begin
            last_vld_q <= 1'b0;
            last_x_q   <= '0;
            last_y_q   <= '0;
        end else if (accept) begin
            last_vld_q <= 1'b1;
            last_x_q   <= det_x;
            last_y_q   <= det_y;
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        start_coll = 1'b0;
        accept     = 1'b0;
        drop_ovf   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fs_rise) begin
                    start_coll = 1'b1;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (fs_rise) begin
                    start_coll = 1'b1;
                end else begin
                    if (det_valid && !merge_hit) begin
                        if (count_q < CAP_V) accept   = 1'b1;
                        else                 drop_ovf = 1'b1;
                    end
                    if (frame_end) state_d = WAIT_WIN;
                end
            end
            WAIT_WIN: if (update_allow) state_d = COMMIT;
            COMMIT:   if (count_q == '0 || last_wr) state_d = PUBLISH;
            PUBLISH:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fs_q       <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            rd_addr_q  <= '0;
            rd_vld_q   <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            bpn_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            fs_q     <= frame_start;
            done_q   <= 1'b0;
            rd_vld_q <= rd_en;
            wen_q    <= rd_vld_q;
            if (rd_en) begin
                rd_ptr_q  <= rd_ptr_q + ONE;
                rd_addr_q <= rd_ptr_q;
            end
            if (rd_vld_q) begin
                waddr_q <= rd_addr_q;
                wdata_q <= ram_rdata;
            end
            if (start_coll) begin
                count_q    <= '0;
                overflow_q <= 1'b0;
            end
            if (accept)   count_q    <= count_q + ONE;
            if (drop_ovf) overflow_q <= 1'b1;
            // Hide the table from the consumer while it is being rewritten.
            if (state_q == WAIT_WIN && state_d == COMMIT) begin
                bpn_q    <= '0;
                rd_ptr_q <= '0;
            end
            if (state_q == PUBLISH) begin
                bpn_q  <= count_q;
                done_q <= 1'b1;
            end
        end
    end

    bpw_stage_ram #(
        .DEPTH(CAP_N),
        .AW   (BAD_POINT_BIT),
        .DW   (32)
    ) u_stage (
        .clk_i  (clk),
        .we_i   (accept),
        .waddr_i(count_q),
        .wdata_i(pack_coord(16'(det_y), 16'(det_x))),
        .re_i   (rd_en),
        .raddr_i(rd_ptr_q),
        .rdata_o(ram_rdata)
    );

    assign wen_lut       = wen_q;
    assign waddr_lut     = waddr_q;
    assign wdata_lut     = wdata_q;
    assign bad_point_num = bpn_q;
    assign commit_done   = done_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q != IDLE) && (state_q != COLLECT);

endmodule

// File: tb/tb_bad_point_list_writer.sv
// Scoreboard bench: stimulus pushes expected LUT writes/publishes, a monitor pops and compares.
module tb_bad_point_list_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0, frame_end = 1'b0, det_valid = 1'b0, update_allow = 1'b0;
    logic [9:0]  det_x = '0, det_y = '0;
    logic        wen_lut, commit_done, overflow, busy;
    logic [6:0]  waddr_lut, bad_point_num;
    logic [31:0] wdata_lut;

    int errors = 0;
    int checks = 0;

    logic [38:0] exp_wr[$];   // {addr, data}
    logic [7:0]  exp_pub[$];  // {overflow, count}
    logic        prev_wen = 1'b0;

    bad_point_list_writer dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .det_valid(det_valid), .det_x(det_x), .det_y(det_y), .update_allow(update_allow),
        .wen_lut(wen_lut), .waddr_lut(waddr_lut), .wdata_lut(wdata_lut),
        .bad_point_num(bad_point_num), .commit_done(commit_done),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every LUT write and every publish against the scoreboard.
    always @(negedge clk) begin
        logic [38:0] w;
        logic [7:0]  p;
        if (wen_lut === 1'b1) begin
            check("bpn_zero_during_write", 64'(bad_point_num), 64'd0);
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 64'(waddr_lut), 64'hFFFF);
            end else begin
                w = exp_wr.pop_front();
                check("waddr_lut", 64'(waddr_lut), 64'(w[38:32]));
                check("wdata_lut", 64'(wdata_lut), 64'(w[31:0]));
            end
            if (waddr_lut != 7'd0) check("writes_back_to_back", 64'(prev_wen), 64'd1);
        end
        if (commit_done === 1'b1) begin
            if (exp_pub.size() == 0) begin
                check("unexpected_commit_done", 64'(bad_point_num), 64'hFFFF);
            end else begin
                p = exp_pub.pop_front();
                check("bad_point_num", 64'(bad_point_num), 64'(p[6:0]));
                check("overflow", 64'(overflow), 64'(p[7]));
            end
        end
        prev_wen = (wen_lut === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_wr(input int addr, input logic [31:0] data);
        exp_wr.push_back({7'(addr), data});
    endtask

    task automatic sof();
        frame_start = 1'b1; tick(); tick();
        frame_start = 1'b0; tick();
    endtask

    task automatic eof();
        frame_end = 1'b1; tick();
        frame_end = 1'b0; tick();
    endtask

    task automatic det(input int x, input int y);
        det_valid = 1'b1; det_x = 10'(x); det_y = 10'(y); tick();
        det_valid = 1'b0;
    endtask

    task automatic open_window();
        bit seen;
        seen = 1'b0;
        update_allow = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (commit_done === 1'b1) begin seen = 1'b1; break; end
        end
        check("commit_done_seen", 64'(seen), 64'd1);
        update_allow = 1'b0;
        tick(); tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"},      64'(wen_lut),       64'd0);
        check({tag, "_waddr"},    64'(waddr_lut),     64'd0);
        check({tag, "_wdata"},    64'(wdata_lut),     64'd0);
        check({tag, "_bpn"},      64'(bad_point_num), 64'd0);
        check({tag, "_done"},     64'(commit_done),   64'd0);
        check({tag, "_overflow"}, 64'(overflow),      64'd0);
        check({tag, "_busy"},     64'(busy),          64'd0);
    endtask

    initial begin
        bit hit;
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic three-entry frame.
        sof();
        det(3, 5); det(4, 100); det(639, 511);
        check("busy_in_collect", 64'(busy), 64'd0);
        eof();
        push_wr(0, 32'h0005_0003);
        push_wr(1, 32'h0064_0004);
        push_wr(2, 32'h01FF_027F);
        exp_pub.push_back({1'b0, 7'd3});
        open_window();

        // Capacity overflow: 130 offered, 127 stored.
        sof();
        for (int i = 0; i < 130; i++) begin
            det_valid = 1'b1; det_x = 10'(i); det_y = 10'd7; tick();
            if (i < 127) push_wr(i, {16'd7, 16'(i)});
        end
        det_valid = 1'b0;
        eof();
        check("overflow_sticky", 64'(overflow), 64'd1);
        exp_pub.push_back({1'b1, 7'd127});
        open_window();

        // Empty frame.
        sof(); eof();
        exp_pub.push_back({1'b0, 7'd0});
        open_window();

        // Long wait for the window; detections in the gap must be ignored.
        sof();
        det(1, 2); det(30, 40);
        eof();
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 3) begin
                det_valid = 1'b1; det_x = 10'(900 + i); det_y = 10'd999;
            end else begin
                det_valid = 1'b0;
            end
            tick();
            check("busy_waiting", 64'(busy), 64'd1);
        end
        det_valid = 1'b0;
        push_wr(0, 32'h0002_0001);
        push_wr(1, 32'h0028_001E);
        exp_pub.push_back({1'b0, 7'd2});
        open_window();

        // Collection restart on a second SOF before EOF.
        sof();
        det(50, 60); det(51, 60);
        sof();
        det(70, 80);
        eof();
        push_wr(0, 32'h0050_0046);
        exp_pub.push_back({1'b0, 7'd1});
        open_window();

        // Reset on the second write of a five-entry commit.
        sof();
        for (int i = 0; i < 5; i++) det(100 + i, 200);
        eof();
        push_wr(0, {16'd200, 16'd100});
        push_wr(1, {16'd200, 16'd101});
        update_allow = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (wen_lut === 1'b1 && waddr_lut == 7'd1) begin hit = 1'b1; break; end
        end
        check("second_write_seen", 64'(hit), 64'd1);
        rst = 1'b1; update_allow = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst = 1'b0;
        tick(); tick();
        check("no_write_after_reset", 64'(wen_lut), 64'd0);

        // Next frame after reset commits normally.
        sof();
        det(7, 8); det(9, 10);
        eof();
        push_wr(0, 32'h0008_0007);
        push_wr(1, 32'h000A_0009);
        exp_pub.push_back({1'b0, 7'd2});
        open_window();

        // Same-row neighbour suppression.
        sof();
        det(10, 20); det(12, 20); det(13, 20); det(10, 21);
        eof();
`ifdef BPW_ROW_MERGE_EN
        push_wr(0, 32'h0014_000A);
        push_wr(1, 32'h0014_000D);
        push_wr(2, 32'h0015_000A);
        exp_pub.push_back({1'b0, 7'd3});
`else
        push_wr(0, 32'h0014_000A);
        push_wr(1, 32'h0014_000C);
        push_wr(2, 32'h0014_000D);
        push_wr(3, 32'h0015_000A);
        exp_pub.push_back({1'b0, 7'd4});
`endif
        open_window();

        tick(); tick();
        check("writes_outstanding", 64'(exp_wr.size()), 64'd0);
        check("publishes_outstanding", 64'(exp_pub.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bad_point_list_writer.md
Name: bad_point_list_writer

Overview:
Collects auto-detected bad-pixel coordinates from the pixel pipeline during a frame and stages them locally. When the frame ends and the update window opens, it writes them into the manual-coordinate LUT write port as {Y[15:0], X[15:0]} words and then publishes the valid-entry count. It is the writer side of the coordinate-table interface consumed by the manual bad-pixel checker. It replaces AXI writes when auto-update mode is selected.

Parameters:
WIDTH_BITS, 10, X coordinate width
HEIGHT_BITS, 10, Y coordinate width
BAD_POINT_BIT, 7, LUT address and count width; capacity CAP = 2^BAD_POINT_BIT - 1 (127)

Ports:
clk  in  1  processing clock; all logic is on its rising edge
rst  in  1  synchronous, active-high reset
frame_start  in  1  SOF level; a rising edge starts collection
frame_end  in  1  EOF single-cycle pulse
det_valid  in  1  detection strobe, qualifies det_x/det_y
det_x  in  WIDTH_BITS  detected X (raster order)
det_y  in  HEIGHT_BITS  detected Y
update_allow  in  1  high while the table consumer may be rewritten (vertical blank)
wen_lut  out  1  LUT write enable
waddr_lut  out  BAD_POINT_BIT  LUT write address
wdata_lut  out  32  {16'(Y), 16'(X)}, zero-extended
bad_point_num  out  BAD_POINT_BIT  published valid-entry count
commit_done  out  1  one-cycle pulse after publish
overflow  out  1  sticky per frame: more than CAP detections were offered
busy  out  1  high in every state except IDLE and COLLECT

Behaviour:
- Reset values: wen_lut=0, waddr_lut=0, wdata_lut=0, bad_point_num=0, commit_done=0, overflow=0, busy=0. State=IDLE, staging count=0.
- Staging store: CAP entries of {Y,X}. Read latency is 1 cycle.
- IDLE: a rising edge of frame_start moves to COLLECT, clears the staging count and clears overflow.
- COLLECT:
  - A det_valid entry is accepted if count < CAP and is stored at address count; count then increments.
  - If count == CAP, the detection is dropped and overflow is set.
  - frame_end moves to WAIT_WIN.
  - A frame_start rising edge without a preceding frame_end restarts collection: count and overflow are cleared and the state stays COLLECT.
- WAIT_WIN: waits for update_allow=1, then moves to COMMIT. det_valid is ignored.
- COMMIT:
  - On entry, bad_point_num is forced to 0 so the consumer never scans a half-written table.
  - Staging address k is read; the next cycle drives wen_lut=1, waddr_lut=k, wdata_lut=entry k.
  - Writes are one per cycle and back-to-back; the first write is 2 cycles after entry.
  - After the write of entry count-1, the state moves to PUBLISH.
  - count == 0 goes directly to PUBLISH with no writes.
- PUBLISH (1 cycle): bad_point_num <= count, commit_done=1, then IDLE.
- The update_allow falling edge during COMMIT is ignored; the commit always completes. busy tells upstream control not to reopen the window.
- A frame_start rising edge while in WAIT_WIN, COMMIT or PUBLISH is ignored. That frame is not collected, and the next SOF seen in IDLE starts collection.
- Reset mid-COMMIT: wen_lut drops in the same clock edge and bad_point_num stays 0. The table is treated as empty until the next commit.
- Previously published table words beyond the new count are left untouched; they are harmless because the consumer bounds its scan by bad_point_num.

Optional Feature:
BPW_ROW_MERGE_EN
- Defined: a detection is dropped (not counted, no overflow effect) when det_y equals the last accepted Y and det_x <= last accepted X + 2. Detections already covered by the consumer's 5x5 region are therefore not stored. The last-accepted register is cleared at collection start.
- Undefined: every det_valid is accepted subject only to capacity.

Decomposition:
- Package bpw_pkg holds:
  - state enum (IDLE, COLLECT, WAIT_WIN, COMMIT, PUBLISH);
  - function pack_coord(y, x) returning 32 bits;
  - localparam CAP.
- Sub-module bpw_stage_ram: single-clock simple dual-port RAM, CAP x 32, 1-cycle registered read.

Test Plan:
- Detections (3,5), (4,100), (639,511) in a frame, EOF, then update_allow=1 -> writes 0x00050003, 0x00640004, 0x01FF027F at addresses 0..2 on consecutive cycles. bad_point_num is 0 during the writes, then 3, with commit_done high for one cycle.
- 130 detections in a frame -> 127 writes, overflow=1, bad_point_num=127.
- Empty frame -> no wen_lut, bad_point_num=0, commit_done pulses.
- update_allow held low for 50 cycles after EOF -> no writes and busy=1 until update_allow rises; det_valid pulses in that gap are ignored.
- Reset asserted on the 2nd write of a 5-entry commit -> wen_lut=0 on the next edge, all outputs return to reset values, and the next frame commits normally.
- With BPW_ROW_MERGE_EN: (10,20), (12,20), (13,20), (10,21) -> 3 entries stored: (10,20), (13,20), (10,21). Without it -> 4 entries stored.
